hv_alu_arbiter: RTL and testbench

//  Shares one combinational hv_alu_pe (instantiated inside) between NumReq requesters.
//  A round-robin arbiter grants one request per cycle.
//  The granted request's A/B/op go through the ALU and the result is captured in an output register.
//  The result is returned on a valid/ready port tagged with the requester ID.

---
 rtl/hv_alu_arbiter.sv | 128 ++++++++++++
 tb/tb_hv_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_alu_arbiter.sv
// Round-robin arbiter sharing one combinational hypervector ALU between NumReq
// requesters; the result is registered and returned on a valid/ready port with the requester ID.

module hv_alu_pe #(
  parameter int HVDimension = 512,
  parameter int NumOpsWidth = 2
) (
  input  logic [HVDimension-1:0] a_i,
  input  logic [HVDimension-1:0] b_i,
  input  logic [NumOpsWidth-1:0] op_i,
  output logic [HVDimension-1:0] c_o
);
  always_comb begin
    c_o = a_i ^ b_i;
    case (op_i)
      NumOpsWidth'(1): c_o = a_i & b_i;
      NumOpsWidth'(2): c_o = a_i | b_i;
      default:         c_o = a_i ^ b_i;
    endcase
  end
endmodule

module hv_alu_arbiter #(
  parameter int HVDimension = 512,
  parameter int NumReq      = 4,
  parameter int NumOps      = 4,
  parameter int NumOpsWidth = $clog2(NumOps),
  parameter int ReqIdWidth  = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*HVDimension-1:0] req_a_i,
  input  logic [NumReq*HVDimension-1:0] req_b_i,
  input  logic [NumReq*NumOpsWidth-1:0] req_op_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [HVDimension-1:0]        res_c_o,
  output logic [ReqIdWidth-1:0]         res_id_o
);
  logic [NumReq-1:0][HVDimension-1:0] a_arr, b_arr;
  logic [NumReq-1:0][NumOpsWidth-1:0] op_arr;

  for (genvar r = 0; r < NumReq; r++) begin : g_unpack
    assign a_arr[r]  = req_a_i[r*HVDimension +: HVDimension];
    assign b_arr[r]  = req_b_i[r*HVDimension +: HVDimension];
    assign op_arr[r] = req_op_i[r*NumOpsWidth +: NumOpsWidth];
  end

  logic                   res_valid_q, res_valid_d;
  logic [HVDimension-1:0] res_c_q, res_c_d;
  logic [ReqIdWidth-1:0]  res_id_q, res_id_d;
  logic [ReqIdWidth-1:0]  rr_ptr_q, rr_ptr_d;

  logic                   found;
  logic [ReqIdWidth-1:0]  grant_idx;
  logic                   out_free;
  logic                   accept;
  logic [HVDimension-1:0] alu_c;

  // Scan from rr_ptr with explicit wrap so non-power-of-2 NumReq works.
  always_comb begin
    int idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req_valid_i[idx]) begin
        found     = 1'b1;
        grant_idx = ReqIdWidth'(idx);
      end
    end
  end

  assign out_free = !res_valid_q || res_ready_i;
  assign accept   = found && out_free && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  hv_alu_pe #(
    .HVDimension(HVDimension),
    .NumOpsWidth(NumOpsWidth)
  ) u_alu (
    .a_i (a_arr[grant_idx]),
    .b_i (b_arr[grant_idx]),
    .op_i(op_arr[grant_idx]),
    .c_o (alu_c)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_c_d     = alu_c;
      res_id_d    = grant_idx;
      rr_ptr_d    = (grant_idx == ReqIdWidth'(NumReq-1)) ? '0 : grant_idx + ReqIdWidth'(1);
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_c_o     = res_c_q;
  assign res_id_o    = res_id_q;
endmodule

// File: tb/tb_hv_alu_arbiter.sv
// Directed bench for hv_alu_arbiter: a 4-requester 512-bit instance and a
// 3-requester 16-bit instance for the wrap/odd-count case.

module tb_hv_alu_arbiter;
  localparam int W  = 512;
  localparam int N  = 4;
  localparam int W3 = 16;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   rv, rr;
  logic [N*W-1:0] ra, rb;
  logic [N*2-1:0] rop;
  logic           res_valid, res_ready;
  logic [W-1:0]   res_c;
  logic [1:0]     res_id;

  logic [N3-1:0]    rv3, rr3;
  logic [N3*W3-1:0] ra3, rb3;
  logic [N3*2-1:0]  rop3;
  logic             res_valid3, res_ready3;
  logic [W3-1:0]    res_c3;
  logic [1:0]       res_id3;

  hv_alu_arbiter #(.HVDimension(W), .NumReq(N), .NumOps(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_ready_o(rr),
    .req_a_i(ra), .req_b_i(rb), .req_op_i(rop),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_c_o(res_c), .res_id_o(res_id));

  hv_alu_arbiter #(.HVDimension(W3), .NumReq(N3), .NumOps(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv3), .req_ready_o(rr3),
    .req_a_i(ra3), .req_b_i(rb3), .req_op_i(rop3),
    .res_valid_o(res_valid3), .res_ready_i(res_ready3),
    .res_c_o(res_c3), .res_id_o(res_id3));

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] pf0, pff, p0f;
  logic [W-1:0] exp_c;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rr_data(int r);
    return {(W/8){8'(r + 1)}};
  endfunction

  task automatic test_reset();
    rst = 1'b1; rv = '1; res_ready = 1'b1;
    rv3 = '1; res_ready3 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if (rr !== 4'b0000 || res_valid !== 1'b0 || res_c !== '0 || res_id !== 2'd0) begin
        miscompares++;
        $display("FAIL reset cyc%0d: ready=%b valid=%b id=%0d c0=%h (want 0,0,0,0)",
                 c, rr, res_valid, res_id, res_c[31:0]);
      end
      vectors++;
      if (rr3 !== 3'b000 || res_valid3 !== 1'b0 || res_c3 !== '0) begin
        miscompares++;
        $display("FAIL reset3 cyc%0d: ready=%b valid=%b c=%h (want 0)", c, rr3, res_valid3, res_c3);
      end
    end
    rst = 1'b0; rv = '0; rv3 = '0;
  endtask

  task automatic test_single_op();
    logic [W-1:0] want [4];
    want[0] = p0f; want[1] = pf0; want[2] = pff; want[3] = p0f;
    ra[0 +: W] = pf0; rb[0 +: W] = pff; res_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      rop[1:0] = 2'(op);
      rv = 4'b0001;
      #1;
      vectors++;
      if (rr !== 4'b0001) begin
        miscompares++;
        $display("FAIL single_ready op%0d: got %b want 0001", op, rr);
      end
      step();
      rv = '0;
      vectors++;
      if (res_valid !== 1'b1 || res_id !== 2'd0 || res_c !== want[op]) begin
        miscompares++;
        $display("FAIL single_op op%0d: valid=%b id=%0d c=%h want 1,0,%h",
                 op, res_valid, res_id, res_c[31:0], want[op][31:0]);
      end
    end
    step();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; step(); rst = 1'b0;
    for (int r = 0; r < N; r++) begin
      ra[r*W +: W] = rr_data(r);
      rb[r*W +: W] = '0;
      rop[r*2 +: 2] = 2'd0;
    end
    res_ready = 1'b1;
    rv = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (res_valid !== 1'b1 || res_id !== 2'(i % N) || res_c !== rr_data(i % N)) begin
        miscompares++;
        $display("FAIL round_robin #%0d: valid=%b id=%0d c=%h want 1,%0d,%h",
                 i, res_valid, res_id, res_c[7:0], i % N, rr_data(i % N) & 8'hFF);
      end
    end
  endtask

  // Continues from round robin: output holds requester 3, pointer back at 0.
  task automatic test_backpressure();
    res_ready = 1'b0;
    #1;
    vectors++;
    if (rr !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_ready_pre: got %b want 0000", rr);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (res_valid !== 1'b1 || res_id !== 2'd3 || res_c !== rr_data(3) || rr !== 4'b0000) begin
        miscompares++;
        $display("FAIL backpressure cyc%0d: valid=%b id=%0d ready=%b c=%h want 1,3,0000,%h",
                 c, res_valid, res_id, rr, res_c[7:0], rr_data(3) & 8'hFF);
      end
    end
    res_ready = 1'b1;
    #1;
    vectors++;
    if (rr !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 0001", rr);
    end
    step();
    rv = '0;
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_c !== rr_data(0)) begin
      miscompares++;
      $display("FAIL bp_release_result: valid=%b id=%0d want 1,0", res_valid, res_id);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    // Pointer is 1 here; accepting requester 1 moves it to 2.
    rv = 4'b0010; res_ready = 1'b1;
    step();
    rv = '0; res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      miscompares++;
      $display("FAIL midop_fill: valid=%b id=%0d want 1,1", res_valid, res_id);
    end
    rst = 1'b1; rv = 4'b1010;
    #1;
    vectors++;
    if (rr !== 4'b0000) begin
      miscompares++;
      $display("FAIL midop_ready_in_reset: got %b want 0000", rr);
    end
    step();
    rst = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || res_c !== '0 || res_id !== 2'd0) begin
      miscompares++;
      $display("FAIL midop_reset: valid=%b id=%0d want 0,0", res_valid, res_id);
    end
    res_ready = 1'b1;
    #1;
    vectors++;
    if (rr !== 4'b0010) begin
      miscompares++;
      $display("FAIL midop_first_grant: got %b want 0010", rr);
    end
    step();
    rv = '0;
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      miscompares++;
      $display("FAIL midop_first_result: valid=%b id=%0d want 1,1", res_valid, res_id);
    end
  endtask

  task automatic test_wrap_odd();
    // req0 AND, req1 XOR via op 3, req2 OR; B = 00FF for all.
    ra3 = {16'h3333, 16'h2222, 16'h1111};
    rb3 = {3{16'h00FF}};
    rop3 = {2'd2, 2'd3, 2'd1};
    res_ready3 = 1'b1;
    rv3 = 3'b010;
    step();
    vectors++;
    if (res_valid3 !== 1'b1 || res_id3 !== 2'd1 || res_c3 !== 16'h22DD) begin
      miscompares++;
      $display("FAIL wrap_r1: valid=%b id=%0d c=%h want 1,1,22dd", res_valid3, res_id3, res_c3);
    end
    rv3 = 3'b101;
    #1;
    vectors++;
    if (rr3 !== 3'b100) begin
      miscompares++;
      $display("FAIL wrap_grant2: got %b want 100", rr3);
    end
    step();
    rv3 = 3'b001;
    vectors++;
    if (res_id3 !== 2'd2 || res_c3 !== 16'h33FF) begin
      miscompares++;
      $display("FAIL wrap_r2: id=%0d c=%h want 2,33ff", res_id3, res_c3);
    end
    #1;
    vectors++;
    if (rr3 !== 3'b001) begin
      miscompares++;
      $display("FAIL wrap_grant0: got %b want 001", rr3);
    end
    step();
    rv3 = 3'b011;
    vectors++;
    if (res_id3 !== 2'd0 || res_c3 !== 16'h0011) begin
      miscompares++;
      $display("FAIL wrap_r0: id=%0d c=%h want 0,0011", res_id3, res_c3);
    end
    #1;
    vectors++;
    if (rr3 !== 3'b010) begin
      miscompares++;
      $display("FAIL wrap_ptr1: got %b want 010", rr3);
    end
    step();
    rv3 = '0;
  endtask

  initial begin
    pf0 = {(W/8){8'hF0}};
    pff = '1;
    p0f = {(W/8){8'h0F}};
    exp_c = '0;
    rst = 1'b1; rv = '0; ra = '0; rb = '0; rop = '0; res_ready = 1'b0;
    rv3 = '0; ra3 = '0; rb3 = '0; rop3 = '0; res_ready3 = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_wrap_odd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
